// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives start and operands; the slave returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             c_out;

  modport master (output start, a_in, b_in, c_in,
                  input  busy, done, sum_out, c_out);
  modport slave  (input  start, a_in, b_in, c_in,
                  output busy, done, sum_out, c_out);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder reused LSB first over WIDTH cycles.
// The carry lives in a flip-flop between bits; sum bits fill a shift register from the MSB.
module full_adder (
  output logic sum,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             c_out_q, c_out_d;
  logic             fa_sum, fa_cout;

  full_adder u_fa (fa_sum, fa_cout, a_sr_q[0], b_sr_q[0], carry_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_out_q <= '0;
      c_out_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      sum_sr_q  <= sum_sr_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum_out_q <= sum_out_d;
      c_out_q   <= c_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_out_d = sum_out_q;
    c_out_d   = c_out_q;
    unique case (state_q)
      // DONE accepts a new start exactly like IDLE so operations can run back to back
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_sr_d   = bus.a_in;
          b_sr_d   = bus.b_in;
          carry_d  = bus.c_in;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_out_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
          c_out_d   = fa_cout;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign bus.sum_out = sum_out_q;
  assign bus.c_out   = c_out_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed table, ignored-start and
// async-reset sequences, then random operations against a plain-arithmetic reference.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ops = 0;
  int   done_cnt = 0;
  logic [8:0] prev = '0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus ();
  serial_adder #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always @(negedge clk) if (!rst && bus.done === 1'b1) done_cnt++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    int         gap;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Starts an op at the current (post-edge) sample point and follows it to done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int glitch, input string nm, output logic [8:0] res);
    logic [8:0] exp;
    int lat, bc;
    exp = 9'(a) + 9'(b) + 9'(c);
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b; bus.c_in = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a_in = 8'($urandom); bus.b_in = 8'($urandom); bus.c_in = 1'($urandom);
    ops++;
    check({nm, "_hold"}, 32'({bus.c_out, bus.sum_out}), 32'(prev));
    lat = 0; bc = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) bc++;
      bus.start = (lat == glitch);
      if (lat == glitch) begin bus.a_in = 8'hFF; bus.b_in = 8'hFF; bus.c_in = 1'b1; end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check({nm, "_latency"}, 32'(lat), 32'd8);
    check({nm, "_busy_cycles"}, 32'(bc), 32'd8);
    res = {bus.c_out, bus.sum_out};
    check({nm, "_result"}, 32'(res), 32'(exp));
    prev = exp;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [8:0] r;
    int d0;
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.c_in = 1'b0;
    //            a      b      c     s      co    gap
    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 2};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1};
    tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1};
    tbl[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 0};
    tbl[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 3};
    tbl[6] = '{8'h01, 8'h7F, 1'b0, 8'h80, 1'b0, 0};

    #12;
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_result", 32'({bus.c_out, bus.sum_out}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      idle(tbl[i].gap);
      run_op(tbl[i].a, tbl[i].b, tbl[i].c, -1, $sformatf("vec%0d", i), r);
      check($sformatf("vec%0d_table", i), 32'(r), 32'({tbl[i].co, tbl[i].s}));
    end

    // start pulsed mid-operation must be ignored
    idle(1);
    run_op(8'h12, 8'h34, 1'b0, 3, "ignored_start", r);
    check("ignored_start_table", 32'(r), 32'h046);

    // async reset in the middle of an op clears outputs without waiting for an edge
    idle(1);
    bus.start = 1'b1; bus.a_in = 8'h01; bus.b_in = 8'h01; bus.c_in = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idle(3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus.busy), 0);
    check("async_rst_done", 32'(bus.done), 0);
    check("async_rst_result", 32'({bus.c_out, bus.sum_out}), 0);
    prev = '0;
    #10 rst = 1'b0;
    @(posedge clk); #1;
    d0 = done_cnt;
    idle(12);
    check("no_done_after_rst", 32'(done_cnt - d0), 0);
    check("idle_after_rst_busy", 32'(bus.busy), 0);

    d0 = done_cnt;
    ops = 0;
    for (int i = 0; i < 1500; i++) begin
      idle(int'($urandom_range(0, 2)));
      run_op(8'($urandom), 8'($urandom), 1'($urandom), -1, "rand", r);
    end
    idle(2);
    check("done_count", 32'(done_cnt - d0), 32'(ops));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
